// File: rtl/hex_token_parser.sv
// Purpose: converts an ASCII character stream into WIDTH-bit words parsed from hexadecimal tokens.
// Latency: the word is presented one cycle after its terminating delimiter is accepted.
// Backpressure: out_valid holds until out_ready; rx_ready is low for as long as a word is held.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   rx_data/rx_valid        incoming ASCII character (bit 7 set = invalid character)
//   rx_ready                character accepted this cycle when high (equals !out_valid)
//   out_value/out_digits    parsed value (zero-extended) and its hex digit count
//   out_valid/out_ready     output handshake
//   error                   one-cycle pulse when a token is rejected (malformed or oversized)
//
// Build option: define HEX_TOKEN_PARSER_LOWERCASE_EN to accept 'a'-'f' as hex digits.
module hex_token_parser #(
   parameter int WIDTH = 32
) (
   input  logic                                 clock,
   input  logic                                 reset_n,
   input  logic [7:0]                           rx_data,
   input  logic                                 rx_valid,
   output logic                                 rx_ready,
   output logic [WIDTH-1:0]                     out_value,
   output logic [$clog2((WIDTH/4)+1)-1:0]       out_digits,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 error
);

   localparam int MAX_DIGITS = WIDTH / 4;
   localparam int CW         = $clog2(MAX_DIGITS + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_SKIP  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] acc, acc_n;
   logic [CW-1:0]    count, count_n;
   logic [WIDTH-1:0] out_value_n;
   logic [CW-1:0]    out_digits_n;
   logic             out_valid_n;
   logic             error_n;

   logic             is_digit;
   logic             is_delim;
   logic [3:0]       nibble;
   logic             accept;
   logic [WIDTH+3:0] acc_shift;

   // Only registered state feeds rx_ready, so there is no path from rx_valid/out_ready.
   assign rx_ready = !out_valid;
   assign accept   = rx_valid && rx_ready;

   // Shift through a wider vector so the expression stays legal down to WIDTH=4.
   assign acc_shift = {acc, nibble};

   // Character classification.
   always_comb begin
      is_digit = 1'b0;
      is_delim = 1'b0;
      nibble   = 4'd0;
      if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
         is_digit = 1'b1;
         nibble   = rx_data[3:0];
      end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
         is_digit = 1'b1;
         nibble   = rx_data[3:0] + 4'd9;
      end
`ifdef HEX_TOKEN_PARSER_LOWERCASE_EN
      else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
         is_digit = 1'b1;
         nibble   = rx_data[3:0] + 4'd9;
      end
`endif
      else if (rx_data == 8'h20 || rx_data == 8'h09 || rx_data == 8'h0D ||
               rx_data == 8'h0A || rx_data == 8'h2C) begin
         is_delim = 1'b1;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_n      = state;
      acc_n        = acc;
      count_n      = count;
      out_value_n  = out_value;
      out_digits_n = out_digits;
      out_valid_n  = out_valid;
      error_n      = 1'b0;

      // No character is accepted while a word is held, so the handshake
      // never collides with a new word being loaded.
      if (out_valid && out_ready) begin
         out_valid_n = 1'b0;
      end

      if (accept) begin
         case (state)
            S_IDLE: begin
               if (is_digit) begin
                  acc_n   = {{(WIDTH-4){1'b0}}, nibble};
                  count_n = CW'(1);
                  state_n = S_ACCUM;
               end else if (!is_delim) begin
                  error_n = 1'b1;
                  state_n = S_SKIP;
               end
            end
            S_ACCUM: begin
               if (is_digit) begin
                  if (count == CW'(MAX_DIGITS)) begin
                     error_n = 1'b1;
                     state_n = S_SKIP;
                  end else begin
                     acc_n   = acc_shift[WIDTH-1:0];
                     count_n = count + 1'b1;
                  end
               end else if (is_delim) begin
                  out_value_n  = acc;
                  out_digits_n = count;
                  out_valid_n  = 1'b1;
                  state_n      = S_IDLE;
               end else begin
                  error_n = 1'b1;
                  state_n = S_SKIP;
               end
            end
            S_SKIP: begin
               // The rejected token has already reported its single error.
               if (is_delim) begin
                  state_n = S_IDLE;
               end
            end
            default: begin
               state_n = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         acc        <= '0;
         count      <= '0;
         out_value  <= '0;
         out_digits <= '0;
         out_valid  <= 1'b0;
         error      <= 1'b0;
      end else begin
         state      <= state_n;
         acc        <= acc_n;
         count      <= count_n;
         out_value  <= out_value_n;
         out_digits <= out_digits_n;
         out_valid  <= out_valid_n;
         error      <= error_n;
      end
   end

endmodule
